mem_stage: RTL and testbench

Fourth stage of the 5-stage RV32I pipeline: takes the EX/MEM pipeline register contents, performs data-memory loads and stores over a req/gnt/rvalid handshake, and registers the results for the write-back stage. Handles byte/halfword/word lane steering, load sign/zero extension and memory wait states. While an access is outstanding it stalls the upstream stages.

---
 rtl/pipeline_pkg.sv | 28 ++
 rtl/mem_load_align.sv | 46 ++++
 rtl/mem_stage.sv | 184 ++++++++++++++++++
 tb/tb_mem_stage.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// ============================================================================
// Module  : pipeline_pkg
// Brief   : Shared RV32I pipeline constants: load/store funct3 codes and
//           the data-memory access FSM state encoding.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package pipeline_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_RESP = 2'd2
  } mem_state_t;

endpackage

`default_nettype wire

// File: rtl/mem_load_align.sv
// ============================================================================
// Module  : mem_load_align
// Brief   : Extracts the addressed byte/halfword from a load word and
//           sign- or zero-extends it according to funct3.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_load_align
  import pipeline_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_byte = i_rdata[7:0];
    case (i_addr_lo)
      2'd1:    w_byte = i_rdata[15:8];
      2'd2:    w_byte = i_rdata[23:16];
      2'd3:    w_byte = i_rdata[31:24];
      default: w_byte = i_rdata[7:0];
    endcase
    w_half = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
  end

  // Undefined funct3 codes fall through to a full-word load.
  always_comb begin
    o_data = i_rdata;
    case (i_funct3)
      F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  o_data = {24'h0, w_byte};
      F3_LH:   o_data = {{16{w_half[15]}}, w_half};
      F3_LHU:  o_data = {16'h0, w_half};
      default: o_data = i_rdata;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mem_stage.sv
// ============================================================================
// Module  : mem_stage
// Brief   : RV32I MEM stage: data-memory req/gnt/rvalid access, lane steering,
//           load extension and MEM/WB register. Optional misaligned-access
//           trap is enabled by defining MEM_MISALIGN_TRAP_EN.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_stage
  import pipeline_pkg::*;
(
  input  logic        clk,
  input  logic        rst_,
  input  logic        ex_valid,
  input  logic [31:0] ex_alu,
  input  logic [31:0] ex_store_data,
  input  logic [4:0]  ex_rd_addr,
  input  logic [2:0]  ex_funct3,
  input  logic        ex_mem_read,
  input  logic        ex_mem_write,
  input  logic        ex_reg_write,
  input  logic        ex_mem_to_reg,
  output logic        mem_stall,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_gnt,
  input  logic        dmem_rvalid,
  input  logic [31:0] dmem_rdata,
  output logic [31:0] mem_wb_alu,
  output logic [31:0] mem_wb_data,
  output logic [4:0]  wb_rd_addr,
  output logic        wb_reg_write,
  output logic        wb_mem_to_reg,
  output logic        mem_misalign
);

  logic        r_s_valid;
  logic [31:0] r_s_alu;
  logic [31:0] r_s_store_data;
  logic [4:0]  r_s_rd;
  logic [2:0]  r_s_funct3;
  logic        r_s_mem_read;
  logic        r_s_mem_write;
  logic        r_s_reg_write;
  logic        r_s_mem_to_reg;

  mem_state_t  r_state;
  mem_state_t  w_state_nxt;
  logic        w_complete;
  logic        w_req;
  logic        w_mem_op;
  logic        w_misalign;
  logic [3:0]  w_be;
  logic [31:0] w_wdata;
  logic [31:0] w_load_data;

  assign w_mem_op = r_s_mem_read | r_s_mem_write;

`ifdef MEM_MISALIGN_TRAP_EN
  // SH shares its funct3 with LH and SW with LW, so these cover stores too.
  assign w_misalign = r_s_valid && w_mem_op && (r_state == MEM_IDLE) &&
                      ((((r_s_funct3 == F3_LH) || (r_s_funct3 == F3_LHU)) && r_s_alu[0]) ||
                       ((r_s_funct3 == F3_LW) && (r_s_alu[1:0] != 2'b00)));
`else
  assign w_misalign = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_s_valid      <= 1'b0;
      r_s_alu        <= 32'h0;
      r_s_store_data <= 32'h0;
      r_s_rd         <= 5'h0;
      r_s_funct3     <= 3'h0;
      r_s_mem_read   <= 1'b0;
      r_s_mem_write  <= 1'b0;
      r_s_reg_write  <= 1'b0;
      r_s_mem_to_reg <= 1'b0;
    end else if (!mem_stall) begin
      r_s_valid      <= ex_valid;
      r_s_alu        <= ex_alu;
      r_s_store_data <= ex_store_data;
      r_s_rd         <= ex_rd_addr;
      r_s_funct3     <= ex_funct3;
      r_s_mem_read   <= ex_mem_read;
      r_s_mem_write  <= ex_mem_write;
      r_s_reg_write  <= ex_reg_write;
      r_s_mem_to_reg <= ex_mem_to_reg;
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) r_state <= MEM_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_req       = 1'b0;
    w_complete  = 1'b0;
    case (r_state)
      MEM_IDLE: begin
        if (r_s_valid) begin
          if (!w_mem_op || w_misalign) begin
            w_complete = 1'b1;
          end else begin
            w_req       = 1'b1;
            w_state_nxt = dmem_gnt ? MEM_RESP : MEM_REQ;
          end
        end
      end
      MEM_REQ: begin
        w_req = 1'b1;
        if (dmem_gnt) w_state_nxt = MEM_RESP;
      end
      MEM_RESP: begin
        if (dmem_rvalid) begin
          w_complete  = 1'b1;
          w_state_nxt = MEM_IDLE;
        end
      end
      default: w_state_nxt = MEM_IDLE;
    endcase
  end

  always_comb begin
    w_be    = 4'b1111;
    w_wdata = r_s_store_data;
    case (r_s_funct3[1:0])
      2'b00: begin
        w_be    = 4'b0001 << r_s_alu[1:0];
        w_wdata = {4{r_s_store_data[7:0]}};
      end
      2'b01: begin
        w_be    = 4'b0011 << {r_s_alu[1], 1'b0};
        w_wdata = {2{r_s_store_data[15:0]}};
      end
      default: begin
        w_be    = 4'b1111;
        w_wdata = r_s_store_data;
      end
    endcase
  end

  mem_load_align u_load_align (
    .i_funct3  (r_s_funct3),
    .i_addr_lo (r_s_alu[1:0]),
    .i_rdata   (dmem_rdata),
    .o_data    (w_load_data)
  );

  assign dmem_req     = w_req;
  assign dmem_we      = w_req & r_s_mem_write;
  assign dmem_addr    = w_req ? {r_s_alu[31:2], 2'b00} : 32'h0;
  assign dmem_be      = w_req ? w_be : 4'b0000;
  assign dmem_wdata   = w_req ? w_wdata : 32'h0;
  assign mem_stall    = r_s_valid & ~w_complete;
  assign mem_misalign = w_misalign;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      mem_wb_alu    <= 32'h0;
      mem_wb_data   <= 32'h0;
      wb_rd_addr    <= 5'h0;
      wb_reg_write  <= 1'b0;
      wb_mem_to_reg <= 1'b0;
    end else if (w_complete) begin
      mem_wb_alu    <= r_s_alu;
      mem_wb_data   <= r_s_mem_read ? w_load_data : 32'h0;
      wb_rd_addr    <= r_s_rd;
      wb_reg_write  <= r_s_reg_write & ~w_misalign;
      wb_mem_to_reg <= r_s_mem_to_reg;
    end else begin
      wb_reg_write  <= 1'b0;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mem_stage.sv
// ============================================================================
// Module  : tb_mem_stage
// Brief   : Directed self-checking bench for mem_stage with a reactive
//           gnt/rvalid memory responder (MEM_MISALIGN_TRAP_EN aware).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst_ = 1'b0;
  logic        ex_valid = 1'b0;
  logic [31:0] ex_alu = 32'h0;
  logic [31:0] ex_store_data = 32'h0;
  logic [4:0]  ex_rd_addr = 5'h0;
  logic [2:0]  ex_funct3 = 3'h0;
  logic        ex_mem_read = 1'b0;
  logic        ex_mem_write = 1'b0;
  logic        ex_reg_write = 1'b0;
  logic        ex_mem_to_reg = 1'b0;
  logic        mem_stall;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_gnt = 1'b0;
  logic        dmem_rvalid = 1'b0;
  logic [31:0] dmem_rdata = 32'h0;
  logic [31:0] mem_wb_alu;
  logic [31:0] mem_wb_data;
  logic [4:0]  wb_rd_addr;
  logic        wb_reg_write;
  logic        wb_mem_to_reg;
  logic        mem_misalign;

  int total = 0;
  int bad   = 0;

  int          n_req, n_stall, n_pulse;
  logic        o_stable, o_mis, o_we;
  logic [31:0] o_addr, o_wdata, o_wb_alu, o_wb_data;
  logic [3:0]  o_be;
  logic [4:0]  o_wb_rd;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk           (clk),
    .rst_          (rst_),
    .ex_valid      (ex_valid),
    .ex_alu        (ex_alu),
    .ex_store_data (ex_store_data),
    .ex_rd_addr    (ex_rd_addr),
    .ex_funct3     (ex_funct3),
    .ex_mem_read   (ex_mem_read),
    .ex_mem_write  (ex_mem_write),
    .ex_reg_write  (ex_reg_write),
    .ex_mem_to_reg (ex_mem_to_reg),
    .mem_stall     (mem_stall),
    .dmem_req      (dmem_req),
    .dmem_we       (dmem_we),
    .dmem_addr     (dmem_addr),
    .dmem_be       (dmem_be),
    .dmem_wdata    (dmem_wdata),
    .dmem_gnt      (dmem_gnt),
    .dmem_rvalid   (dmem_rvalid),
    .dmem_rdata    (dmem_rdata),
    .mem_wb_alu    (mem_wb_alu),
    .mem_wb_data   (mem_wb_data),
    .wb_rd_addr    (wb_rd_addr),
    .wb_reg_write  (wb_reg_write),
    .wb_mem_to_reg (wb_mem_to_reg),
    .mem_misalign  (mem_misalign)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h want=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [31:0] alu, input logic [31:0] sd,
                        input logic [4:0] rd, input logic [2:0] f3, input logic mr,
                        input logic mw, input logic rw, input logic m2r);
    ex_valid      = v;
    ex_alu        = alu;
    ex_store_data = sd;
    ex_rd_addr    = rd;
    ex_funct3     = f3;
    ex_mem_read   = mr;
    ex_mem_write  = mw;
    ex_reg_write  = rw;
    ex_mem_to_reg = m2r;
  endtask

  // Issue one instruction and act as memory: gnt on the (gnt_dly+1)-th request
  // cycle, rvalid rv_dly+1 cycles after the grant.
  task automatic run_op(input logic [31:0] alu, input logic [31:0] sd, input logic [4:0] rd,
                        input logic [2:0] f3, input logic mr, input logic mw, input logic rw,
                        input logic m2r, input int gnt_dly, input int rv_dly,
                        input logic [31:0] rdata);
    int  req_cnt, since;
    bit  granted, done, seen;
    req_cnt = 0; since = 0; granted = 0; done = 0; seen = 0;
    n_req = 0; n_stall = 0; n_pulse = 0; o_stable = 1'b1; o_mis = 1'b0;
    o_addr = 32'h0; o_be = 4'h0; o_wdata = 32'h0; o_we = 1'b0;
    set_ex(1'b1, alu, sd, rd, f3, mr, mw, rw, m2r);
    tick;
    ex_valid = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      n_pulse += int'(wb_reg_write);
      if (granted) since++;
      dmem_rvalid = granted && (since == rv_dly + 1);
      dmem_rdata  = dmem_rvalid ? rdata : 32'hDEAD_0000;
      dmem_gnt    = 1'b0;
      if (dmem_req && !granted) begin
        dmem_gnt = (req_cnt == gnt_dly);
        req_cnt++;
        if (dmem_gnt) begin
          granted = 1;
          since   = 0;
        end
      end
      #1;
      if (c == 0) o_mis = mem_misalign;
      if (dmem_req) begin
        n_req++;
        if (!seen) begin
          seen = 1; o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we = dmem_we;
        end else if (dmem_addr !== o_addr || dmem_be !== o_be ||
                     dmem_wdata !== o_wdata || dmem_we !== o_we) begin
          o_stable = 1'b0;
        end
      end
      if (mem_stall) n_stall++;
      else           done = 1;
      @(posedge clk);
      #1;
    end
    dmem_gnt    = 1'b0;
    dmem_rvalid = 1'b0;
    o_wb_alu  = mem_wb_alu;
    o_wb_data = mem_wb_data;
    o_wb_rd   = wb_rd_addr;
    n_pulse  += int'(wb_reg_write);
    tick;
    n_pulse  += int'(wb_reg_write);
    if (!done) chk("op_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_stall", {31'h0, mem_stall}, 32'h0);
    chk("rst_req", {31'h0, dmem_req}, 32'h0);
    chk("rst_addr", dmem_addr, 32'h0);
    chk("rst_wb_rw", {31'h0, wb_reg_write}, 32'h0);
    chk("rst_wb_alu", mem_wb_alu, 32'h0);
    chk("rst_mis", {31'h0, mem_misalign}, 32'h0);
    @(negedge clk);
    rst_ = 1'b1;
    tick;

    // ADD -> rd5
    run_op(32'h0000_1234, 32'h0, 5'd5, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0, 32'h0);
    chk("add_stall", n_stall, 0);
    chk("add_req", n_req, 0);
    chk("add_pulse", n_pulse, 1);
    chk("add_rd", {27'h0, o_wb_rd}, 32'd5);
    chk("add_alu", o_wb_alu, 32'h0000_1234);

    // SB 0xAB @0x103
    run_op(32'h0000_0103, 32'h0000_00AB, 5'd0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0);
    chk("sb_addr", o_addr, 32'h0000_0100);
    chk("sb_be", {28'h0, o_be}, 32'h8);
    chk("sb_wdata", o_wdata, 32'hABAB_ABAB);
    chk("sb_we", {31'h0, o_we}, 32'h1);
    chk("sb_stall", n_stall, 1);
    chk("sb_pulse", n_pulse, 0);

    // LB / LBU @0x102
    run_op(32'h0000_0102, 32'h0, 5'd7, 3'b000, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0080_0000);
    chk("lb_data", o_wb_data, 32'hFFFF_FF80);
    chk("lb_pulse", n_pulse, 1);
    chk("lb_rd", {27'h0, o_wb_rd}, 32'd7);
    run_op(32'h0000_0102, 32'h0, 5'd7, 3'b100, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0080_0000);
    chk("lbu_data", o_wb_data, 32'h0000_0080);

    // Halfword steering / extension
    run_op(32'h0000_0102, 32'h0, 5'd8, 3'b001, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 32'h8001_0000);
    chk("lh_data", o_wb_data, 32'hFFFF_8001);
    run_op(32'h0000_0100, 32'h0, 5'd8, 3'b101, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 32'h0000_F00F);
    chk("lhu_data", o_wb_data, 32'h0000_F00F);
    run_op(32'h0000_0102, 32'h1234_BEEF, 5'd0, 3'b001, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0);
    chk("sh_be", {28'h0, o_be}, 32'hC);
    chk("sh_wdata", o_wdata, 32'hBEEF_BEEF);
    run_op(32'h0000_0204, 32'hDEAD_BEEF, 5'd0, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0, 32'h0);
    chk("sw_be", {28'h0, o_be}, 32'hF);
    chk("sw_wdata", o_wdata, 32'hDEAD_BEEF);
    chk("sw_addr", o_addr, 32'h0000_0204);

    // LW with wait states
    run_op(32'h0000_0200, 32'h0, 5'd9, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 3, 1, 32'h1234_5678);
    chk("lwd_req", n_req, 4);
    chk("lwd_stable", {31'h0, o_stable}, 32'h1);
    chk("lwd_stall", n_stall, 5);
    chk("lwd_pulse", n_pulse, 1);
    chk("lwd_data", o_wb_data, 32'h1234_5678);

    // Misaligned LW @0x102
    run_op(32'h0000_0102, 32'h0, 5'd4, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 0, 0, 32'hCAFE_F00D);
`ifdef MEM_MISALIGN_TRAP_EN
    chk("mis_req", n_req, 0);
    chk("mis_flag", {31'h0, o_mis}, 32'h1);
    chk("mis_pulse", n_pulse, 0);
    chk("mis_stall", n_stall, 0);
`else
    chk("mis_req", n_req, 1);
    chk("mis_addr", o_addr, 32'h0000_0100);
    chk("mis_be", {28'h0, o_be}, 32'hF);
    chk("mis_flag", {31'h0, o_mis}, 32'h0);
    chk("mis_data", o_wb_data, 32'hCAFE_F00D);
`endif
    tick;
    chk("mis_flag_after", {31'h0, mem_misalign}, 32'h0);

    // Back-to-back non-memory instructions
    set_ex(1'b1, 32'd11, 32'h0, 5'd1, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick;
    set_ex(1'b1, 32'd22, 32'h0, 5'd2, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0);
    tick;
    ex_valid = 1'b0;
    chk("b2b_rd1", {27'h0, wb_rd_addr}, 32'd1);
    chk("b2b_rw1", {31'h0, wb_reg_write}, 32'h1);
    tick;
    chk("b2b_alu2", mem_wb_alu, 32'd22);
    chk("b2b_rw2", {31'h0, wb_reg_write}, 32'h1);
    tick;

    // Reset while waiting for rvalid
    set_ex(1'b1, 32'h0000_0300, 32'h0, 5'd3, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1);
    tick;
    ex_valid = 1'b0;
    dmem_gnt = 1'b1;
    tick;
    dmem_gnt = 1'b0;
    chk("rr_in_resp", {31'h0, mem_stall}, 32'h1);
    rst_ = 1'b0;
    #1;
    chk("rr_stall", {31'h0, mem_stall}, 32'h0);
    chk("rr_req", {31'h0, dmem_req}, 32'h0);
    chk("rr_wb_alu", mem_wb_alu, 32'h0);
    chk("rr_wb_rd", {27'h0, wb_rd_addr}, 32'h0);
    @(negedge clk);
    rst_ = 1'b1;
    tick;
    dmem_rvalid = 1'b1;
    dmem_rdata  = 32'h5555_AAAA;
    tick;
    dmem_rvalid = 1'b0;
    chk("rr_late_rw", {31'h0, wb_reg_write}, 32'h0);
    chk("rr_late_data", mem_wb_data, 32'h0);
    chk("rr_idle_stall", {31'h0, mem_stall}, 32'h0);
    chk("rr_idle_req", {31'h0, dmem_req}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
